johnson_phase_decoder: RTL

Downstream consumer of the 5-bit Johnson counter: samples the counter's code word, decodes it to a phase index and a one-hot phase strobe, and tracks lock, code integrity and completed revolutions. It sits between the Johnson counter's `Q` bus and any logic that needs a 10-phase sequencer with fault detection. It must tolerate the counter being preset, held or corrupted, and must never report a phase it has not verified.

---
 rtl/johnson_phase_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: samples a 5-bit Johnson code, decodes it to a phase index
// and one-hot strobe, and tracks lock, code integrity and completed revolutions.
module johnson_phase_decoder #(
    parameter int LOCK_COUNT = 3,
    parameter int REV_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 Reset,
    input  logic                 en,
    input  logic [4:0]           Q,
    input  logic                 clr,
    output logic [3:0]           phase,
    output logic [9:0]           phase_onehot,
    output logic                 valid,
    output logic                 locked,
    output logic                 illegal,
    output logic                 skip_err,
    output logic [REV_WIDTH-1:0] rev_count,
    output logic                 rev_tick
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lockState_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [3:0] LAST_PHASE  = 4'd9;

    lockState_t state;
    logic [3:0] run;
    logic [4:0] storedCode;

    logic       sampleLegal;
    logic [3:0] samplePhase;
    logic [3:0] nextPhase;
    logic       isHold;
    logic       isSuccessor;
    logic       isWrap;

    // Decode the sampled code and classify it against the last stored legal code.
    always_comb begin
        sampleLegal = 1'b1;
        samplePhase = 4'd0;
        case (Q)
            5'b00000: samplePhase = 4'd0;
            5'b00001: samplePhase = 4'd1;
            5'b00011: samplePhase = 4'd2;
            5'b00111: samplePhase = 4'd3;
            5'b01111: samplePhase = 4'd4;
            5'b11111: samplePhase = 4'd5;
            5'b11110: samplePhase = 4'd6;
            5'b11100: samplePhase = 4'd7;
            5'b11000: samplePhase = 4'd8;
            5'b10000: samplePhase = 4'd9;
            default: begin
                sampleLegal = 1'b0;
                samplePhase = 4'd0;
            end
        endcase
        nextPhase   = (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
        isHold      = sampleLegal && (Q == storedCode);
        isSuccessor = sampleLegal && (samplePhase == nextPhase);
        isWrap      = isSuccessor && (phase == LAST_PHASE);
    end

    // Lock state machine, stored code, sticky flags and revolution counter.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state      <= UNLOCKED;
            run        <= 4'd0;
            storedCode <= 5'b00000;
            phase      <= 4'd0;
            illegal    <= 1'b0;
            skip_err   <= 1'b0;
            rev_count  <= '0;
            rev_tick   <= 1'b0;
        end else begin
            rev_tick <= 1'b0;
            if (clr) begin
                illegal  <= 1'b0;
                skip_err <= 1'b0;
            end
            if (en) begin
                if (!sampleLegal) begin
                    state   <= UNLOCKED;
                    run     <= 4'd0;
                    illegal <= 1'b1;
                end else begin
                    phase      <= samplePhase;
                    storedCode <= Q;
                    case (state)
                        UNLOCKED: begin
                            state <= LOCKING;
                            run   <= 4'd0;
                        end
                        LOCKING: begin
                            if (isHold) begin
                                run <= run;
                            end else if (isSuccessor) begin
                                run <= run + 4'd1;
                                if (run + 4'd1 == LOCK_TARGET) begin
                                    state <= LOCKED;
                                end
                            end else begin
                                run <= 4'd0;
                            end
                        end
                        LOCKED: begin
                            if (isHold) begin
                                run <= run;
                            end else if (isSuccessor) begin
                                if (isWrap) begin
                                    rev_count <= rev_count + 1'b1;
                                    rev_tick  <= 1'b1;
                                end
                            end else begin
                                state    <= LOCKING;
                                run      <= 4'd0;
                                skip_err <= 1'b1;
                            end
                        end
                        default: begin
                            state <= UNLOCKED;
                            run   <= 4'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Lock indication and strobe come straight from registered state, never from Q.
    always_comb begin
        locked       = (state == LOCKED);
        valid        = locked;
        phase_onehot = locked ? (10'b1 << phase) : 10'b0;
    end

endmodule
